pmem_loader_ctrl: RTL and testbench
===================================

Name: pmem_loader_ctrl

Overview:
- Sequences the LOAD phase of the microcontroller: accepts a program as a valid/ready stream of 12-bit instructions and writes it into program memory over the PMem load port.
- Verifies a running checksum, then releases the core by asserting cpu_run, which sends the core state machine from LOAD to FETCH.
- Replaces the fixed-length, file-based program load with a length-programmable, host-driven load.

Parameters:
- ADDR_W, 8, program-memory address width.
- INST_W, 12, instruction width.
- CSUM_W, 8, checksum width (modulo-2^CSUM_W sum of all instruction bits taken as INST_W-bit words, truncated).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle pulse; begins a load. Sampled only in IDLE, RUN or ERR.
- prog_len  in  ADDR_W  instruction count minus one (0 means 1 instruction, 255 means 256); captured on start.
- exp_csum  in  CSUM_W  expected checksum; captured on start.
- abort  in  1  level; cancels an in-progress load.
- in_valid  in  1  stream beat valid.
- in_inst  in  INST_W  stream instruction.
- in_ready  out  1  controller accepts beat.
- pm_le  out  1  PMem load enable (one write per cycle).
- pm_addr  out  ADDR_W  PMem load address.
- pm_inst  out  INST_W  PMem load data.
- cpu_run  out  1  core enable; 0 holds the core in LOAD.
- busy  out  1  high in LOAD or CHECK.
- load_done  out  1  one-cycle pulse on successful load.
- load_err  out  1  sticky until next start or reset; checksum mismatch or abort.
- beat_cnt  out  ADDR_W+1  instructions written in the current or last load.

Behaviour:
- Reset (rst=0 at a clock edge) applies to all outputs: state=IDLE, in_ready=0, pm_le=0, pm_addr=0, pm_inst=0, cpu_run=0, busy=0, load_done=0, load_err=0, beat_cnt=0, csum=0.
- Reset mid-load discards the partial load. No further pm_le.
- States are IDLE, LOAD, CHECK, RUN and ERR.
- IDLE: in_ready=0.
  - start -> LOAD.
  - On entry to LOAD: capture prog_len and exp_csum; clear beat_cnt, csum and load_err; cpu_run=0.
- LOAD: in_ready=1.
  - Beat accepted when in_valid & in_ready.
  - Latency 1: beat accepted at edge N gives pm_le=1, pm_addr=beat_cnt(old), pm_inst=in_inst at cycle N+1. beat_cnt increments and csum += in_inst[CSUM_W-1:0] at the same edge.
  - pm_le=0 in every cycle with no accepted beat. Back-to-back beats give one write per cycle.
  - When the accepted beat is number prog_len+1: in_ready drops in the next cycle -> CHECK. Extra stream beats are not accepted.
  - abort=1 in LOAD (checked before acceptance; the beat in that cycle is not accepted) -> ERR with load_err=1.
  - A start pulse in LOAD is ignored.
- CHECK: one cycle, in_ready=0.
  - The final write (pm_le) is issued in this cycle.
  - csum==exp_csum -> RUN, with load_done=1 for one cycle (the cycle after CHECK) and cpu_run=1 from that cycle on.
  - Mismatch -> ERR, load_err=1.
  - abort in CHECK is ignored.
- RUN: cpu_run=1, in_ready=0.
  - start -> LOAD with cpu_run=0 from the next cycle (reload halts the core).
- ERR: cpu_run=0, in_ready=0, load_err=1.
  - start -> LOAD; load_err clears.
- Width rules:
  - beat_cnt is ADDR_W+1 bits so a 256-instruction load reads 256.
  - pm_addr uses beat_cnt[ADDR_W-1:0].
  - csum wraps modulo 2^CSUM_W.
- Simultaneous events: rst dominates everything, then abort, then beat acceptance.

Decomposition:
- Shared package (mc_pkg), shared with the core control unit:
  - Loader state encoding constants: IDLE=3'd0, LOAD=3'd1, CHECK=3'd2, RUN=3'd3, ERR=3'd4.
  - ADDR_W and INST_W defaults.
- One sub-module, pmem_write_stage: the registered pm_le/pm_addr/pm_inst output stage, with synchronous active-low clear.
- The FSM, counter and checksum stay in the top module.

Test Plan:
- Nominal load: prog_len=2, beats 0x101,0x202,0x303 back-to-back, exp_csum=0x06.
  - Writes at addr 0,1,2 in consecutive cycles, one cycle after each acceptance.
  - load_done pulse one cycle after CHECK; cpu_run=1; beat_cnt=3.
- Stalling source: same program with in_valid low for 2 cycles between beats.
  - pm_le=0 in gap cycles.
  - Addresses stay contiguous; result identical to the nominal load.
- Checksum error: prog_len=0, beat 0x0FF, exp_csum=0x00.
  - One write at addr 0, then ERR with load_err=1, cpu_run=0, no load_done.
  - A subsequent start clears load_err.
- Abort: prog_len=9, assert abort after 4 beats.
  - Exactly 4 writes (addr 0-3); the beat presented with abort is not accepted.
  - ERR, load_err=1, beat_cnt=4.
- Full depth and wrap: prog_len=255, 256 beats of value i.
  - Last write at addr 255; beat_cnt=256.
  - exp_csum=0x80 (sum of 0..255 mod 256) -> RUN.
  - A further valid beat is not accepted.
- Reset mid-load: rst=0 after 3 beats.
  - All outputs are at reset values next cycle; no pm_le afterwards.
  - A restart loads from addr 0.

Source files
------------

// File: rtl/mc_pkg.sv
// mc_pkg: loader state encoding and datapath width defaults shared with the core control unit.
package mc_pkg;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_INST_W = 12;
  localparam int DEF_CSUM_W = 8;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    RUN   = 3'd3,
    ERR   = 3'd4
  } ld_state_t;
endpackage

// File: rtl/pmem_loader_ctrl_if.sv
// pmem_loader_ctrl_if: instruction stream handshake and PMem load port.
interface pmem_loader_ctrl_if #(
  parameter int ADDR_W = mc_pkg::DEF_ADDR_W,
  parameter int INST_W = mc_pkg::DEF_INST_W
);
  logic              in_valid;
  logic              in_ready;
  logic [INST_W-1:0] in_inst;
  logic              pm_le;
  logic [ADDR_W-1:0] pm_addr;
  logic [INST_W-1:0] pm_inst;
  modport master (output in_valid, in_inst, input in_ready, pm_le, pm_addr, pm_inst);
  modport slave (input in_valid, in_inst, output in_ready, pm_le, pm_addr, pm_inst);
endinterface

// File: rtl/pmem_write_stage.sv
// pmem_write_stage: registered PMem load port, one write per accepted beat.
module pmem_write_stage #(
  parameter int ADDR_W = mc_pkg::DEF_ADDR_W,
  parameter int INST_W = mc_pkg::DEF_INST_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [INST_W-1:0] inst,
  output logic              pm_le,
  output logic [ADDR_W-1:0] pm_addr,
  output logic [INST_W-1:0] pm_inst
);
  always_ff @(posedge clk) begin
    if (!rst) begin
      pm_le   <= 1'b0;
      pm_addr <= '0;
      pm_inst <= '0;
    end else begin
      pm_le <= we;
      if (we) begin
        pm_addr <= addr;
        pm_inst <= inst;
      end
    end
  end
endmodule

// File: rtl/pmem_loader_ctrl.sv
// pmem_loader_ctrl: streams a length-programmed program into PMem, verifies its checksum, then releases the core.
module pmem_loader_ctrl
  import mc_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int INST_W = DEF_INST_W,
  parameter int CSUM_W = DEF_CSUM_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] prog_len,
  input  logic [CSUM_W-1:0] exp_csum,
  input  logic              abort,
  pmem_loader_ctrl_if.slave bus,
  output logic              cpu_run,
  output logic              busy,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   beat_cnt
);
  ld_state_t         state, state_nx;
  logic [ADDR_W-1:0] len_q;
  logic [CSUM_W-1:0] exp_q, csum;
  logic              acc, last, entry;
  // abort takes priority over acceptance, so in_ready is withdrawn while it is high
  assign bus.in_ready = state == LOAD && !abort;
  assign acc          = bus.in_valid && bus.in_ready;
  assign last         = beat_cnt == {1'b0, len_q};
  assign entry        = state != LOAD && state_nx == LOAD;
  assign cpu_run      = state == RUN;
  assign busy         = state == LOAD || state == CHECK;
  assign load_err     = state == ERR;
  always_comb begin
    state_nx = state;
    state_nx = state == LOAD ? (abort ? ERR : (acc && last) ? CHECK : LOAD)
             : state == CHECK ? (csum == exp_q ? RUN : ERR)
             : state inside {IDLE, RUN, ERR} ? (start ? LOAD : state)
             : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      len_q     <= '0;
      exp_q     <= '0;
      csum      <= '0;
      beat_cnt  <= '0;
      load_done <= 1'b0;
    end else begin
      state     <= state_nx;
      load_done <= state == CHECK && csum == exp_q;
      if (entry) begin
        len_q    <= prog_len;
        exp_q    <= exp_csum;
        csum     <= '0;
        beat_cnt <= '0;
      end else if (acc) begin
        csum     <= csum + bus.in_inst[CSUM_W-1:0];
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end
  pmem_write_stage #(.ADDR_W(ADDR_W), .INST_W(INST_W)) u_wr (
    .clk    (clk),
    .rst    (rst),
    .we     (acc),
    .addr   (beat_cnt[ADDR_W-1:0]),
    .inst   (bus.in_inst),
    .pm_le  (bus.pm_le),
    .pm_addr(bus.pm_addr),
    .pm_inst(bus.pm_inst)
  );
endmodule

// File: tb/tb_pmem_loader_ctrl.sv
// tb_pmem_loader_ctrl: table-driven, directed and randomized checks of the program loader.
module tb_pmem_loader_ctrl;
  logic       clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0;
  logic [7:0] prog_len = '0, exp_csum = '0;
  logic       cpu_run, busy, load_done, load_err;
  logic [8:0] beat_cnt;
  int         checks = 0, errors = 0;
  pmem_loader_ctrl_if bus ();
  pmem_loader_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .prog_len(prog_len), .exp_csum(exp_csum),
    .abort(abort), .bus(bus), .cpu_run(cpu_run), .busy(busy), .load_done(load_done),
    .load_err(load_err), .beat_cnt(beat_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  // write monitor: every accepted beat must reappear on the load port exactly one cycle later
  logic        mon_en = 1'b0, exp_restart = 1'b0, acc_prev = 1'b0;
  logic [7:0]  ea = '0;
  logic [11:0] ei = '0;
  int          mdl_cnt = 0, wr_cnt = 0, done_cnt = 0;
  always @(negedge clk) if (mon_en) begin
    chk("pm_le", bus.pm_le, acc_prev);
    if (acc_prev) begin
      chk("pm_addr", bus.pm_addr, ea);
      chk("pm_inst", bus.pm_inst, ei);
      wr_cnt++;
    end
    if (load_done) done_cnt++;
    acc_prev = bus.in_valid & bus.in_ready & rst;
    if (acc_prev) begin
      ea = mdl_cnt[7:0];
      ei = bus.in_inst;
      mdl_cnt++;
    end
    if (!rst || (start && exp_restart)) mdl_cnt = 0;
  end
  logic [11:0] prog [256];
  task automatic do_start(input int len, input logic [7:0] c, input logic restart);
    prog_len = 8'(len);
    exp_csum = c;
    start = 1'b1;
    exp_restart = restart;
    @(posedge clk); #1;
    start = 1'b0;
    exp_restart = 1'b0;
  endtask
  task automatic send_beat(input logic [11:0] v, output int cyc);
    logic ok, fin;
    bus.in_valid = 1'b1;
    bus.in_inst = v;
    cyc = 0;
    fin = 1'b0;
    while (!fin) begin
      @(negedge clk); ok = bus.in_ready;
      @(posedge clk); #1;
      cyc++;
      if (ok) fin = 1'b1;
      else if (cyc >= 50) begin
        chk("beat_timeout", 1, 0);
        fin = 1'b1;
      end
    end
    bus.in_valid = 1'b0;
  endtask
  task automatic run_load(input int len, input logic [7:0] c, input int gap, input int abort_after);
    logic [7:0] sum;
    logic       ab, ok;
    int         w0, d0, cyc, tot, n;
    ab = abort_after <= len;
    ok = 1'b0;
    w0 = wr_cnt;
    d0 = done_cnt;
    sum = '0;
    tot = 0;
    n = ab ? abort_after : len + 1;
    do_start(len, c, 1'b1);
    for (int i = 0; i <= len; i++) begin
      if (i > 0) repeat (gap) begin @(posedge clk); #1; end
      if (ab && i == abort_after) begin
        bus.in_valid = 1'b1;
        bus.in_inst = prog[i];
        abort = 1'b1;
        @(negedge clk); chk("abort_rdy", bus.in_ready, 0);
        @(posedge clk); #1;
        abort = 1'b0;
        bus.in_valid = 1'b0;
        break;
      end
      send_beat(prog[i], cyc);
      tot += cyc;
      sum += prog[i][7:0];
    end
    if (!ab) begin
      ok = sum == c;
      if (gap == 0) chk("b2b_cycles", tot, len + 1);
      @(negedge clk);
      chk("chk_busy", busy, 1); chk("chk_rdy", bus.in_ready, 0); chk("chk_run", cpu_run, 0);
      @(negedge clk);
      chk("done_pulse", load_done, ok); chk("run_after", cpu_run, ok); chk("err_after", load_err, !ok);
      @(negedge clk);
      chk("done_1cyc", load_done, 0);
    end
    repeat (2) begin @(posedge clk); #1; end
    chk("beat_cnt", beat_cnt, n);
    chk("writes", wr_cnt - w0, n);
    chk("done_cnt", done_cnt - d0, ok);
    chk("cpu_run", cpu_run, ok);
    chk("load_err", load_err, !ok);
    chk("busy", busy, 0);
  endtask
  typedef struct {
    int len; logic [7:0] csum; logic [11:0] base, step; int gap, ab;
    logic run, err; int cnt;
  } vec_t;
  vec_t tbl [6];
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int cyc, w0;
    logic [7:0] s;
    tbl[0] = '{2, 8'h06, 12'h101, 12'h101, 0, 1000, 1'b1, 1'b0, 3};
    tbl[1] = '{2, 8'h06, 12'h101, 12'h101, 2, 1000, 1'b1, 1'b0, 3};
    tbl[2] = '{0, 8'h00, 12'h0FF, 12'h000, 0, 1000, 1'b0, 1'b1, 1};
    tbl[3] = '{0, 8'hFF, 12'h0FF, 12'h000, 0, 1000, 1'b1, 1'b0, 1};
    tbl[4] = '{9, 8'h00, 12'h010, 12'h001, 0, 4, 1'b0, 1'b1, 4};
    tbl[5] = '{255, 8'h80, 12'h000, 12'h001, 0, 1000, 1'b1, 1'b0, 256};
    bus.in_valid = 1'b0;
    bus.in_inst = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", bus.in_ready, 0); chk("rst_le", bus.pm_le, 0); chk("rst_addr", bus.pm_addr, 0);
    chk("rst_inst", bus.pm_inst, 0); chk("rst_run", cpu_run, 0); chk("rst_busy", busy, 0);
    chk("rst_done", load_done, 0); chk("rst_err", load_err, 0); chk("rst_cnt", beat_cnt, 0);
    rst = 1'b1;
    mon_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i <= tbl[k].len; i++) prog[i] = tbl[k].base + tbl[k].step * 12'(i);
      run_load(tbl[k].len, tbl[k].csum, tbl[k].gap, tbl[k].ab);
      chk($sformatf("tbl%0d_run", k), cpu_run, tbl[k].run);
      chk($sformatf("tbl%0d_err", k), load_err, tbl[k].err);
      chk($sformatf("tbl%0d_cnt", k), beat_cnt, tbl[k].cnt);
    end
    w0 = wr_cnt;
    bus.in_valid = 1'b1;
    bus.in_inst = 12'h123;
    repeat (3) begin @(negedge clk); chk("extra_rdy", bus.in_ready, 0); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("extra_writes", wr_cnt - w0, 0);
    chk("extra_cnt", beat_cnt, 256);
    for (int i = 0; i < 4; i++) prog[i] = 12'h0A0 + 12'(i);
    do_start(3, 8'h86, 1'b1);
    send_beat(prog[0], cyc);
    do_start(0, 8'h55, 1'b0);
    for (int i = 1; i < 4; i++) send_beat(prog[i], cyc);
    repeat (3) begin @(posedge clk); #1; end
    chk("ign_start_cnt", beat_cnt, 4);
    chk("ign_start_run", cpu_run, 1);
    do_start(0, 8'h11, 1'b1);
    chk("reload_run", cpu_run, 0);
    chk("reload_busy", busy, 1);
    send_beat(12'h011, cyc);
    repeat (3) begin @(posedge clk); #1; end
    chk("reload_done", cpu_run, 1);
    for (int i = 0; i < 10; i++) prog[i] = 12'h300 + 12'(i);
    do_start(9, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) send_beat(prog[i], cyc);
    bus.in_valid = 1'b1;
    bus.in_inst = prog[3];
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_ready", bus.in_ready, 0); chk("mrst_le", bus.pm_le, 0); chk("mrst_addr", bus.pm_addr, 0);
    chk("mrst_inst", bus.pm_inst, 0); chk("mrst_run", cpu_run, 0); chk("mrst_busy", busy, 0);
    chk("mrst_done", load_done, 0); chk("mrst_err", load_err, 0); chk("mrst_cnt", beat_cnt, 0);
    repeat (3) begin @(posedge clk); #1; end
    bus.in_valid = 1'b0;
    prog[0] = 12'h101; prog[1] = 12'h202; prog[2] = 12'h303;
    run_load(2, 8'h06, 0, 1000);
    for (int t = 0; t < 25; t++) begin
      int len, gap, ab;
      len = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 15);
      gap = $urandom_range(0, 2);
      s = '0;
      for (int i = 0; i <= len; i++) begin
        prog[i] = 12'($urandom);
        s += prog[i][7:0];
      end
      if ($urandom_range(0, 3) == 0) s += 8'd1;
      ab = ($urandom_range(0, 4) == 0) ? $urandom_range(0, len) : 1000;
      run_load(len, s, gap, ab);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
